cache_bank_arbiter: RTL and testbench

- Sequences one cache bank RAM (1 write port, 4 read ports; CS/WE/RD exclusive per cycle; registered read outputs) between 4 read clients and 1 write client.
- Batches all pending reads into a single RAM read cycle.
- Alternates read and write priority under contention so neither side starves.
- Sits between the bank's load/store clients and the bank RAM; it owns all RAM control and address pins.

---
 rtl/cache_bank_arbiter_pkg.sv | 25 ++
 rtl/cache_bank_arbiter_if.sv | 31 +++
 rtl/cache_bank_arbiter_prio.sv | 29 ++
 rtl/cache_bank_arbiter.sv | 101 ++++++++++
 tb/tb_cache_bank_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_bank_arbiter_pkg.sv
// Shared types and widths for the cache bank arbiter: state/op encodings and the write payload.
package cache_bank_arbiter_pkg;

    // Widths mirror the global cache bank address and data widths.
    localparam int unsigned ADR = 8;
    localparam int unsigned DAT = 32;
    localparam int unsigned NRD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef struct packed {
        logic [ADR-1:0] addr;
        logic [DAT-1:0] data;
    } wr_pay_t;

endpackage

// File: rtl/cache_bank_arbiter_if.sv
// Client and bank RAM signal bundle; master is the arbiter side, slave the clients plus RAM.
interface cache_bank_arbiter_if;
    import cache_bank_arbiter_pkg::*;

    logic [NRD-1:0]          rd_req;
    logic [NRD-1:0][ADR-1:0] rd_addr;
    logic [NRD-1:0]          rd_valid;
    logic [NRD-1:0][DAT-1:0] rd_data;
    logic                    wr_req;
    logic [ADR-1:0]          wr_addr;
    logic [DAT-1:0]          wr_data;
    logic                    wr_ack;
    logic                    ram_cs;
    logic                    ram_we;
    logic                    ram_rd;
    logic [ADR-1:0]          ram_wa;
    logic [NRD-1:0][ADR-1:0] ram_ra;
    logic [DAT-1:0]          ram_din;
    logic [NRD-1:0][DAT-1:0] ram_dout;

    modport master (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_dout,
        output rd_valid, rd_data, wr_ack, ram_cs, ram_we, ram_rd, ram_wa, ram_ra, ram_din
    );

    modport slave (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_dout,
        input  rd_valid, rd_data, wr_ack, ram_cs, ram_we, ram_rd, ram_wa, ram_ra, ram_din
    );

endinterface

// File: rtl/cache_bank_arbiter_prio.sv
// Read/write priority decision: picks the next RAM op and the read grant mask.
module cache_bank_prio
    import cache_bank_arbiter_pkg::*;
(
    input  logic [NRD-1:0] pend,
    input  logic           wr_req,
    input  op_e            last_op,
    input  state_e         state,
    output state_e         next_state_c,
    output logic [NRD-1:0] grant_c
);

    // A write just issued still shows wr_req at this edge, so never re-enter WRITE from WRITE.
    always_comb begin
        next_state_c = ST_IDLE;
        grant_c      = '0;
        if (pend != '0 && !wr_req) begin
            next_state_c = ST_READ;
        end else if (pend == '0 && wr_req && state != ST_WRITE) begin
            next_state_c = ST_WRITE;
        end else if (pend != '0 && wr_req) begin
            next_state_c = (last_op == OP_READ) ? ST_WRITE : ST_READ;
        end
        if (next_state_c == ST_READ) begin
            grant_c = pend;
        end
    end

endmodule

// File: rtl/cache_bank_arbiter.sv
// Cache bank arbiter: batches pending reads into one RAM read cycle and interleaves writes.
module cache_bank_arbiter
    import cache_bank_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    cache_bank_arbiter_if.master bus
);

    state_e                  state_q, state_d;
    op_e                     last_op_q, last_op_d;
    logic [NRD-1:0]          gmask_q, gmask_d;
    logic [NRD-1:0]          rd_valid_q, rd_valid_d;
    logic                    wr_ack_q, wr_ack_d;
    logic                    ram_cs_q, ram_cs_d;
    logic                    ram_we_q, ram_we_d;
    logic                    ram_rd_q, ram_rd_d;
    logic [NRD-1:0][ADR-1:0] ram_ra_q, ram_ra_d;
    wr_pay_t                 wr_q, wr_d;

    logic [NRD-1:0] inflight;
    logic [NRD-1:0] pend;
    state_e         next_state;
    logic [NRD-1:0] grant;

    // Mask clients whose read is in the RAM now or whose data is being returned this cycle.
    always_comb begin
        inflight = (state_q == ST_READ) ? gmask_q : '0;
        pend     = bus.rd_req & ~inflight & ~rd_valid_q;
    end

    cache_bank_prio u_prio (
        .pend         (pend),
        .wr_req       (bus.wr_req),
        .last_op      (last_op_q),
        .state        (state_q),
        .next_state_c (next_state),
        .grant_c      (grant)
    );

    always_comb begin
        state_d    = next_state;
        gmask_d    = grant;
        last_op_d  = last_op_q;
        ram_ra_d   = ram_ra_q;
        wr_d       = wr_q;
        rd_valid_d = (state_q == ST_READ) ? gmask_q : '0;
        wr_ack_d   = (next_state == ST_WRITE);
        ram_cs_d   = (next_state != ST_IDLE);
        ram_we_d   = (next_state == ST_WRITE);
        ram_rd_d   = (next_state == ST_READ);
        if (next_state == ST_READ) begin
            last_op_d = OP_READ;
            for (int i = 0; i < NRD; i++) begin
                ram_ra_d[i] = grant[i] ? bus.rd_addr[i] : '0;
            end
        end
        if (next_state == ST_WRITE) begin
            last_op_d = OP_WRITE;
            wr_d.addr = bus.wr_addr;
            wr_d.data = bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_op_q  <= OP_WRITE;
            gmask_q    <= '0;
            rd_valid_q <= '0;
            wr_ack_q   <= 1'b0;
            ram_cs_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_rd_q   <= 1'b0;
            ram_ra_q   <= '0;
            wr_q       <= '0;
        end else begin
            state_q    <= state_d;
            last_op_q  <= last_op_d;
            gmask_q    <= gmask_d;
            rd_valid_q <= rd_valid_d;
            wr_ack_q   <= wr_ack_d;
            ram_cs_q   <= ram_cs_d;
            ram_we_q   <= ram_we_d;
            ram_rd_q   <= ram_rd_d;
            ram_ra_q   <= ram_ra_d;
            wr_q       <= wr_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = bus.ram_dout;
    assign bus.wr_ack   = wr_ack_q;
    assign bus.ram_cs   = ram_cs_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.ram_rd   = ram_rd_q;
    assign bus.ram_ra   = ram_ra_q;
    assign bus.ram_wa   = wr_q.addr;
    assign bus.ram_din  = wr_q.data;

endmodule

// File: tb/tb_cache_bank_arbiter.sv
// Directed bench for cache_bank_arbiter with a behavioural 1W/4R registered-output bank RAM.
module tb_cache_bank_arbiter;
    import cache_bank_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errs   = 0;
    int   both_err = 0;

    cache_bank_arbiter_if bus ();

    cache_bank_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic           pre_en;
    logic [ADR-1:0] pre_a;
    logic [DAT-1:0] pre_d;
    logic [DAT-1:0] mem [1 << ADR];

    // Bank RAM: write at the edge ending a write cycle, registered read data.
    always @(posedge clk) begin
        if (pre_en) mem[pre_a] <= pre_d;
        if (bus.ram_cs && bus.ram_we) mem[bus.ram_wa] <= bus.ram_din;
        if (bus.ram_cs && bus.ram_rd) begin
            for (int i = 0; i < NRD; i++) bus.ram_dout[i] <= mem[bus.ram_ra[i]];
        end
    end

    always @(negedge clk) begin
        if (bus.ram_we && bus.ram_rd) both_err++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ADR-1:0] a, input logic [DAT-1:0] d);
        pre_en = 1'b1;
        pre_a  = a;
        pre_d  = d;
        tick();
        pre_en = 1'b0;
    endtask

    initial begin
        int n_rd;
        int n_wr;
        int alt_err;
        logic prev_w;
        logic have_prev;

        rst         = 1'b1;
        pre_en      = 1'b0;
        pre_a       = '0;
        pre_d       = '0;
        bus.rd_req  = '0;
        bus.rd_addr = '0;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        tick();
        tick();

        // Reset state
        check("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
        check("rst_wr_ack",   64'(bus.wr_ack),   64'(0));
        check("rst_ram_cs",   64'(bus.ram_cs),   64'(0));
        check("rst_ram_we",   64'(bus.ram_we),   64'(0));
        check("rst_ram_rd",   64'(bus.ram_rd),   64'(0));
        check("rst_ram_wa",   64'(bus.ram_wa),   64'(0));
        check("rst_ram_din",  64'(bus.ram_din),  64'(0));
        check("rst_ram_ra",   64'(bus.ram_ra),   64'(0));

        preload(8'd1, 32'h11);
        preload(8'd2, 32'h22);
        preload(8'd3, 32'h33);
        preload(8'd4, 32'h44);
        preload(8'd5, 32'h00);
        preload(8'd7, 32'h00);
        preload(8'd9, 32'h00);
        rst = 1'b0;

        // Read and write to addr 7 together out of reset: read wins, returns old data
        bus.rd_req     = 4'b0001;
        bus.rd_addr[0] = 8'd7;
        bus.wr_req     = 1'b1;
        bus.wr_addr    = 8'd7;
        bus.wr_data    = 32'hFF;
        tick();
        check("t4_first_rd", 64'(bus.ram_rd), 64'(1));
        check("t4_first_we", 64'(bus.ram_we), 64'(0));
        check("t4_ra0",      64'(bus.ram_ra[0]), 64'(7));
        tick();
        check("t4_we",       64'(bus.ram_we), 64'(1));
        check("t4_ack",      64'(bus.wr_ack), 64'(1));
        check("t4_wa",       64'(bus.ram_wa), 64'(7));
        check("t4_din",      64'(bus.ram_din), 64'(32'hFF));
        check("t4_valid",    64'(bus.rd_valid), 64'(4'b0001));
        check("t4_old_data", 64'(bus.rd_data[0]), 64'(0));
        bus.rd_req = '0;
        bus.wr_req = 1'b0;
        tick();
        check("t4_ack_pulse", 64'(bus.wr_ack), 64'(0));
        check("t4_idle_cs",   64'(bus.ram_cs), 64'(0));
        bus.rd_req = 4'b0001;
        tick();
        tick();
        check("t4_reread_valid", 64'(bus.rd_valid), 64'(4'b0001));
        check("t4_new_data",     64'(bus.rd_data[0]), 64'(32'hFF));
        bus.rd_req = '0;
        tick();

        // Write 0xA5 to addr 5, then read it back from client 2 in the following cycle
        bus.wr_req  = 1'b1;
        bus.wr_addr = 8'd5;
        bus.wr_data = 32'hA5;
        tick();
        check("t2_ack", 64'(bus.wr_ack), 64'(1));
        check("t2_we",  64'(bus.ram_we), 64'(1));
        bus.wr_req     = 1'b0;
        bus.rd_req     = 4'b0100;
        bus.rd_addr[2] = 8'd5;
        tick();
        check("t2_rd",    64'(bus.ram_rd), 64'(1));
        check("t2_valid_early", 64'(bus.rd_valid), 64'(0));
        tick();
        check("t2_valid", 64'(bus.rd_valid), 64'(4'b0100));
        check("t2_data",  64'(bus.rd_data[2]), 64'(32'hA5));
        bus.rd_req = '0;
        tick();

        // All four clients at once: one READ cycle, all valid together
        bus.rd_req  = 4'b1111;
        for (int i = 0; i < NRD; i++) bus.rd_addr[i] = ADR'(i + 1);
        tick();
        check("t3_rd",  64'(bus.ram_rd), 64'(1));
        check("t3_ra",  64'(bus.ram_ra), 64'(32'h04030201));
        tick();
        check("t3_valid", 64'(bus.rd_valid), 64'(4'b1111));
        check("t3_rd_once", 64'(bus.ram_rd), 64'(0));
        for (int i = 0; i < NRD; i++) check("t3_data", 64'(bus.rd_data[i]), 64'((i + 1) * 32'h11));
        tick();
        check("t3_no_dup", 64'(bus.rd_valid), 64'(0));
        check("t3_no_reissue", 64'(bus.ram_rd), 64'(0));
        bus.rd_req = '0;
        tick();

        // Staggered clients 0 then 3: two adjacent READs, no duplicate for client 0
        bus.rd_req     = 4'b0001;
        bus.rd_addr[0] = 8'd1;
        tick();
        bus.rd_req     = 4'b1001;
        bus.rd_addr[3] = 8'd4;
        tick();
        check("t6_second_rd", 64'(bus.ram_rd), 64'(1));
        check("t6_ra3",       64'(bus.ram_ra[3]), 64'(4));
        check("t6_valid0",    64'(bus.rd_valid), 64'(4'b0001));
        check("t6_data0",     64'(bus.rd_data[0]), 64'(32'h11));
        tick();
        check("t6_valid3",    64'(bus.rd_valid), 64'(4'b1000));
        check("t6_data3",     64'(bus.rd_data[3]), 64'(32'h44));
        check("t6_no_dup_rd", 64'(bus.ram_rd), 64'(0));
        bus.rd_req = 4'b1000;
        tick();
        check("t6_quiet",     64'(bus.rd_valid), 64'(0));
        bus.rd_req = '0;
        tick();

        // Reset asserted during a READ abandons it; held requests re-issue afterwards
        bus.rd_req     = 4'b0011;
        bus.rd_addr[0] = 8'd1;
        bus.rd_addr[1] = 8'd2;
        tick();
        check("t1_rd_before_rst", 64'(bus.ram_rd), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("t1_cs_in_rst",    64'(bus.ram_cs), 64'(0));
        check("t1_valid_in_rst", 64'(bus.rd_valid), 64'(0));
        tick();
        check("t1_valid_in_rst2", 64'(bus.rd_valid), 64'(0));
        tick();
        rst = 1'b0;
        tick();
        check("t1_reissue",      64'(bus.ram_rd), 64'(1));
        check("t1_valid_early",  64'(bus.rd_valid), 64'(0));
        tick();
        check("t1_valid",  64'(bus.rd_valid), 64'(4'b0011));
        check("t1_data0",  64'(bus.rd_data[0]), 64'(32'h11));
        check("t1_data1",  64'(bus.rd_data[1]), 64'(32'h22));
        bus.rd_req = '0;
        tick();

        // Continuous contention: last op was READ, so W,R,W,idle,R,W,idle,... over 20 cycles
        bus.wr_req     = 1'b1;
        bus.wr_addr    = 8'd9;
        bus.wr_data    = 32'h55;
        bus.rd_req     = 4'b0010;
        bus.rd_addr[1] = 8'd9;
        n_rd      = 0;
        n_wr      = 0;
        alt_err   = 0;
        prev_w    = 1'b0;
        have_prev = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.wr_ack != bus.ram_we) alt_err++;
            if (bus.ram_rd || bus.ram_we) begin
                if (have_prev && prev_w == bus.ram_we) alt_err++;
                prev_w    = bus.ram_we;
                have_prev = 1'b1;
                if (bus.ram_we) n_wr++;
                else            n_rd++;
            end
        end
        bus.wr_req = 1'b0;
        bus.rd_req = '0;
        tick();
        tick();
        check("t5_alternation", 64'(alt_err), 64'(0));
        check("t5_reads",       64'(n_rd), 64'(7));
        check("t5_writes",      64'(n_wr), 64'(7));
        check("t5_we_and_rd",   64'(both_err), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
